// File: rtl/arb_seq_pkg.sv
// arb_seq_pkg: shared state encoding and operation codes for req_arbiter_sequencer.
package arb_seq_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        ERROR = 2'd3
    } seq_state_e;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
endpackage

// File: rtl/req_arbiter_sequencer_rr_pick.sv
// rr_pick: combinational round-robin pick; first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          any_req
);
    int k;
    // Walk offsets from farthest to nearest so the nearest set request overrides.
    always_comb begin
        win = '0;
        k = 0;
        for (int i = N - 1; i >= 0; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k[PW-1:0]]) win = N'(1) << k;
        end
    end

    assign any_req = |req;
endmodule

// File: rtl/req_arbiter_sequencer.sv
// req_arbiter_sequencer: arbitrates requesters onto a shared burst engine and counts beats.
// Define ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module req_arbiter_sequencer
    import arb_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4
) (
    input  logic                     in_clk,
    input  logic                     in_rst_n,
    input  logic [NUM_REQ-1:0]       in_req,
    input  logic [NUM_REQ*2-1:0]     in_op,
    input  logic [NUM_REQ*LEN_W-1:0] in_len,
    output logic [NUM_REQ-1:0]       out_grant,
    output logic [NUM_REQ-1:0]       out_ack,
    output logic                     out_err,
    output logic [1:0]               out_state,
    output logic                     out_eng_valid,
    input  logic                     in_eng_ready,
    output logic [1:0]               out_eng_op,
    output logic [LEN_W-1:0]         out_eng_len,
    input  logic                     in_eng_beat
);
    localparam int PW = $clog2(NUM_REQ);

    seq_state_e         state_q, nxt_state;
    logic [NUM_REQ-1:0] win, grant_q, ack_q;
    logic               any_req, err_q, valid_q, busy, done;
    logic [PW-1:0]      win_idx;
    logic [1:0]         sel_op, op_q;
    logic [LEN_W-1:0]   sel_len, len_q, cnt_q;

`ifdef ARB_FIXED_PRIO_EN
    rr_pick #(.N(NUM_REQ)) u_pick (.req(in_req), .ptr('0), .win(win), .any_req(any_req));
`else
    logic [PW-1:0] ptr_q, grant_idx;

    rr_pick #(.N(NUM_REQ)) u_pick (.req(in_req), .ptr(ptr_q), .win(win), .any_req(any_req));

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (grant_q[i]) grant_idx = PW'(i);
    end

    always_ff @(posedge in_clk or negedge in_rst_n)
        if (!in_rst_n) ptr_q <= '0;
        else if (done) ptr_q <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
`endif

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) if (win[i]) win_idx = PW'(i);
        sel_op  = in_op[int'(win_idx)*2 +: 2];
        sel_len = in_len[int'(win_idx)*LEN_W +: LEN_W];
        case (sel_op)
            OP_READ:  nxt_state = sel_len != '0 ? READ : ERROR;
            OP_WRITE: nxt_state = sel_len != '0 ? WRITE : ERROR;
            default:  nxt_state = ERROR;
        endcase
    end

    assign busy = state_q == READ || state_q == WRITE;
    // Beats only count once the command has been handed over.
    assign done = state_q == ERROR || (busy && !valid_q && in_eng_beat && cnt_q == LEN_W'(1));

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            op_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            ack_q <= done ? grant_q : '0;
            err_q <= state_q == ERROR;
            unique case (state_q)
                IDLE: if (any_req) begin
                    grant_q <= win;
                    op_q    <= sel_op;
                    len_q   <= sel_len;
                    cnt_q   <= sel_len;
                    valid_q <= nxt_state != ERROR;
                    state_q <= nxt_state;
                end
                READ, WRITE: begin
                    if (valid_q) valid_q <= !in_eng_ready;
                    else if (in_eng_beat && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                    if (done) begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end
                ERROR: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

    assign out_grant     = grant_q;
    assign out_ack       = ack_q;
    assign out_err       = err_q;
    assign out_state     = state_q;
    assign out_eng_valid = valid_q;
    assign out_eng_op    = op_q;
    assign out_eng_len   = len_q;
endmodule

// File: tb/tb_req_arbiter_sequencer.sv
// tb_req_arbiter_sequencer: directed scoreboard bench for req_arbiter_sequencer.
module tb_req_arbiter_sequencer;
    localparam int N  = 4;
    localparam int LW = 4;

    logic          in_clk = 1'b0;
    logic          in_rst_n = 1'b0;
    logic [N-1:0]  in_req = '0;
    logic [2*N-1:0] in_op = '0;
    logic [N*LW-1:0] in_len = '0;
    logic          in_eng_ready = 1'b0;
    logic          in_eng_beat = 1'b0;
    logic [N-1:0]  out_grant, out_ack;
    logic          out_err, out_eng_valid;
    logic [1:0]    out_state, out_eng_op;
    logic [LW-1:0] out_eng_len;

    int n_chk = 0;
    int n_fail = 0;
    logic [N-1:0] exp_grant[$];
    logic [N:0]   exp_ack[$];
    logic [N-1:0] prev_grant = '0;

    req_arbiter_sequencer #(.NUM_REQ(N), .LEN_W(LW)) dut (
        .in_clk(in_clk), .in_rst_n(in_rst_n), .in_req(in_req), .in_op(in_op), .in_len(in_len),
        .out_grant(out_grant), .out_ack(out_ack), .out_err(out_err), .out_state(out_state),
        .out_eng_valid(out_eng_valid), .in_eng_ready(in_eng_ready), .out_eng_op(out_eng_op),
        .out_eng_len(out_eng_len), .in_eng_beat(in_eng_beat)
    );

    always #5 in_clk = ~in_clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endfunction

    // Monitor: pops the scoreboard whenever a grant rises or an ack/err appears.
    always @(negedge in_clk) begin
        if (out_grant != '0 && prev_grant == '0) begin
            if (exp_grant.size() == 0) check("grant_unexpected", 32'(out_grant), 0);
            else check("grant_order", 32'(out_grant), 32'(exp_grant.pop_front()));
        end
        prev_grant <= out_grant;
        if (out_ack != '0 || out_err) begin
            if (exp_ack.size() == 0) check("ack_unexpected", 32'({out_ack, out_err}), 0);
            else check("ack_err", 32'({out_ack, out_err}), 32'(exp_ack.pop_front()));
        end
    end

    task automatic cyc();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_grant();
        int t;
        t = 0;
        do begin
            cyc();
            t++;
        end while (out_grant == '0 && t < 10);
        if (out_grant == '0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_timeout: got %0h, want nonzero", out_grant);
        end
    endtask

    task automatic txn(int idx, logic [1:0] op, logic [LW-1:0] len, int rdy_wait, logic [1:0] exp_state);
        logic [N-1:0] g;
        logic e;
        g = N'(1) << idx;
        e = exp_state == 2'd3;
        in_op[idx*2 +: 2] = op;
        in_len[idx*LW +: LW] = len;
        in_req[idx] = 1'b1;
        exp_grant.push_back(g);
        exp_ack.push_back({g, e});
        wait_grant();
        check("txn_state", 32'(out_state), 32'(exp_state));
        check("txn_valid", 32'(out_eng_valid), 32'(!e));
        check("txn_eng_op", 32'(out_eng_op), 32'(op));
        check("txn_eng_len", 32'(out_eng_len), 32'(len));
        if (!e) begin
            in_eng_beat = 1'b1;
            repeat (rdy_wait) cyc();
            in_eng_ready = 1'b1;
            cyc();
            in_eng_ready = 1'b0;
            in_eng_beat = 1'b0;
            check("txn_valid_drop", 32'(out_eng_valid), 0);
            check("txn_len_hold", 32'(out_eng_len), 32'(len));
            in_eng_beat = 1'b1;
            repeat (int'(len)) cyc();
            in_eng_beat = 1'b0;
        end else cyc();
        check("txn_ack_time", 32'(out_ack), 32'(g));
        check("txn_idle", 32'(out_state), 0);
        in_req[idx] = 1'b0;
    endtask

    initial begin
        logic [N-1:0] g;
        in_req = '1;
        in_op = {N{2'b01}};
        in_len = {N{4'd1}};
        repeat (3) cyc();
        check("rst_grant", 32'(out_grant), 0);
        check("rst_ack", 32'(out_ack), 0);
        check("rst_err", 32'(out_err), 0);
        check("rst_state", 32'(out_state), 0);
        check("rst_valid", 32'(out_eng_valid), 0);
        check("rst_eng_op", 32'(out_eng_op), 0);
        check("rst_eng_len", 32'(out_eng_len), 0);
        for (int k = 0; k < 5; k++) begin
`ifdef ARB_FIXED_PRIO_EN
            g = 4'b0001;
`else
            g = N'(1) << (k % N);
`endif
            exp_grant.push_back(g);
            exp_ack.push_back({g, 1'b0});
        end
        in_rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wait_grant();
            in_eng_ready = 1'b1;
            cyc();
            in_eng_ready = 1'b0;
            in_eng_beat = 1'b1;
            cyc();
            in_eng_beat = 1'b0;
        end
        in_req = '0;
        cyc();
        txn(2, 2'b01, 4'd3, 1, 2'd1);
        txn(1, 2'b11, 4'd2, 0, 2'd3);
        txn(0, 2'b10, 4'd0, 0, 2'd3);
        txn(2, 2'b10, 4'd2, 0, 2'd2);
        in_req[1] = 1'b1;
        in_op[3:2] = 2'b01;
        in_len[7:4] = 4'd5;
        exp_grant.push_back(4'b0010);
        wait_grant();
        in_eng_ready = 1'b1;
        cyc();
        in_eng_ready = 1'b0;
        in_eng_beat = 1'b1;
        cyc();
        in_eng_beat = 1'b0;
        check("mid_state", 32'(out_state), 1);
        #2 in_rst_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(out_state), 0);
        check("mid_rst_grant", 32'(out_grant), 0);
        check("mid_rst_valid", 32'(out_eng_valid), 0);
        check("mid_rst_eng_len", 32'(out_eng_len), 0);
        in_req = '0;
        cyc();
        in_rst_n = 1'b1;
        in_req[3] = 1'b1;
        in_op[7:6] = 2'b01;
        in_len[15:12] = 4'd1;
        txn(0, 2'b01, 4'd1, 0, 2'd1);
        txn(3, 2'b01, 4'd1, 0, 2'd1);
        repeat (3) cyc();
        check("sb_grant_drain", exp_grant.size(), 0);
        check("sb_ack_drain", exp_ack.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end
endmodule
